// File: rtl/hmmm_loader_if.sv
// Signal bundle between the hmmm loader and its surroundings: program stream,
// host I/O register and the hmmm CPU bus/strobes.
interface hmmm_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        io_valid;
  logic [15:0] io_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        restart;
  logic        done;
  logic        cpu_rst;
  logic        cpu_pgrm_addr;
  logic        cpu_pgrm_data;
  logic        cpu_read;
  logic        cpu_write;
  logic        cpu_halt;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_oe;

  modport master (
    input  in_valid, in_data, in_last, io_valid, io_data, restart,
           cpu_read, cpu_write, cpu_halt, bus_in,
    output in_ready, out_valid, out_data, done, cpu_rst,
           cpu_pgrm_addr, cpu_pgrm_data, bus_out, bus_oe
  );

  modport slave (
    output in_valid, in_data, in_last, io_valid, io_data, restart,
           cpu_read, cpu_write, cpu_halt, bus_in,
    input  in_ready, out_valid, out_data, done, cpu_rst,
           cpu_pgrm_addr, cpu_pgrm_data, bus_out, bus_oe
  );
endinterface

// File: rtl/hmmm_loader.sv
// Host-side loader for the hmmm CPU: writes a program word stream into CPU memory
// via address/data strobes, releases the CPU, then services its read/write I/O.
module hmmm_loader #(
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  hmmm_loader_if.master lif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    INIT, FETCH, ADDR, DATA, LRST, RUN, HALTED
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] addr;
  logic [15:0]   word;
  logic          last;
  logic [15:0]   io_reg;
  logic          out_valid_q;
  logic [15:0]   out_data_q;
  logic          load_end;

  // Loading stops on the tagged last word or when memory is full.
  assign load_end = last || (addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      INIT:    next_state = FETCH;
      FETCH:   if (lif.in_valid) next_state = ADDR;
      ADDR:    next_state = DATA;
      DATA:    next_state = load_end ? LRST : FETCH;
      LRST:    next_state = RUN;
      RUN: begin
        if (lif.restart) begin
          next_state = INIT;
        end else if (lif.cpu_halt) begin
          next_state = HALTED;
        end
      end
      HALTED:  if (lif.restart) next_state = INIT;
      default: next_state = INIT;
    endcase
  end

  // io_reg is host state and deliberately survives INIT; only rst clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr        <= '0;
      word        <= '0;
      last        <= 1'b0;
      io_reg      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (lif.io_valid) begin
        io_reg <= lif.io_data;
      end
      out_valid_q <= (state == RUN) && lif.cpu_write;
      if ((state == RUN) && lif.cpu_write) begin
        out_data_q <= lif.bus_in;
      end
      unique case (state)
        INIT: addr <= '0;
        FETCH: begin
          if (lif.in_valid) begin
            word <= lif.in_data;
            last <= lif.in_last;
          end
        end
        DATA: if (!load_end) addr <= addr + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    lif.in_ready      = 1'b0;
    lif.cpu_rst       = 1'b0;
    lif.cpu_pgrm_addr = 1'b0;
    lif.cpu_pgrm_data = 1'b0;
    lif.bus_oe        = 1'b0;
    lif.bus_out       = '0;
    lif.done          = 1'b0;
    lif.out_valid     = out_valid_q;
    lif.out_data      = out_data_q;
    unique case (state)
      INIT, LRST: lif.cpu_rst = 1'b1;
      FETCH:      lif.in_ready = 1'b1;
      ADDR: begin
        lif.cpu_pgrm_addr = 1'b1;
        lif.bus_oe        = 1'b1;
        lif.bus_out       = 16'(addr);
      end
      DATA: begin
        lif.cpu_pgrm_data = 1'b1;
        lif.bus_oe        = 1'b1;
        lif.bus_out       = word;
      end
      RUN: begin
        lif.bus_oe  = lif.cpu_read;
        lif.bus_out = io_reg;
      end
      HALTED:     lif.done = 1'b1;
      default: ;
    endcase
  end

endmodule
